regfile_write_arbiter: RTL

- Shares the single write port of the 8x16 register file between two writeback requesters: A (ALU result) and B (memory load result).
- Each requester uses a valid/ready handshake. The block arbitrates round-robin and registers the winning write into one output stage that drives RegWrite/RD/WriteData.
- Exports a pending-write mask for the hazard logic.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_write_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single write port of the 8x16 register file between two
// writeback requesters: A (ALU result) and B (memory load result). Each
// requester uses a valid/ready handshake. Contended requests are arbitrated
// round-robin, and the winning write is registered into a single output
// stage that drives the register file write port one cycle later.
//
// Ports:
//   Clock       system clock, rising edge active
//   Reset       asynchronous, active-high reset
//   Hold        stall from control; while high nothing is granted
//   AValid/ARd/AData/AReady   requester A handshake, destination and data
//   BValid/BRd/BData/BReady   requester B handshake, destination and data
//   RegWrite    write strobe to the register file
//   RD          write address to the register file
//   WriteData   write data to the register file
//   Pending     one-hot mask of the register being written this cycle
//   LastGrantB  1 when the most recent contended grant went to B
//
// NREG must equal 2**ADDR_W so that every index 0..NREG-1 is addressable.

module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Hold,
    input  logic              AValid,
    input  logic [ADDR_W-1:0] ARd,
    input  logic [DATA_W-1:0] AData,
    output logic              AReady,
    input  logic              BValid,
    input  logic [ADDR_W-1:0] BRd,
    input  logic [DATA_W-1:0] BData,
    output logic              BReady,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] WriteData,
    output logic [NREG-1:0]   Pending,
    output logic              LastGrantB
);

    logic contended;
    logic granted;

    // Grant decision. Ready is purely combinational from the valids, the
    // stall and the round-robin pointer. Under contention the requester
    // that did not win last time is favoured, so LastGrantB=1 hands the
    // next contended slot to A. Reset and Hold both mask every grant, which
    // keeps waiting requesters parked until the pipeline is released. The
    // two ready terms are mutually exclusive by construction.
    always_comb begin
        contended = AValid && BValid;
        AReady    = 1'b0;
        BReady    = 1'b0;
        if (!Reset && !Hold) begin
            if (contended) begin
                AReady = LastGrantB;
                BReady = !LastGrantB;
            end else begin
                AReady = AValid;
                BReady = BValid;
            end
        end
        granted = AReady || BReady;
    end

    // Output stage and round-robin pointer. A transfer on this edge turns
    // into a register file write on the next cycle; without a transfer the
    // strobe drops but RD/WriteData keep their last values so downstream
    // logic never sees spurious address toggles. The pointer only moves on
    // contended grants, so a lone requester cannot starve the other one the
    // next time both show up. Reset kills any in-flight write outright and
    // re-arms the pointer so A wins the first contention.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            RegWrite   <= 1'b0;
            RD         <= '0;
            WriteData  <= '0;
            LastGrantB <= 1'b1;
        end else begin
            RegWrite <= granted;
            if (AReady) begin
                RD        <= ARd;
                WriteData <= AData;
            end else if (BReady) begin
                RD        <= BRd;
                WriteData <= BData;
            end
            if (granted && contended) begin
                LastGrantB <= BReady;
            end
        end
    end

    // Pending mask for the hazard logic. It is decoded from the output
    // registers only, so it reflects exactly the write the register file is
    // taking this cycle and is all zero whenever the strobe is low.
    always_comb begin
        Pending = '0;
        for (int r = 0; r < NREG; r++) begin
            Pending[r] = RegWrite && (RD == ADDR_W'(r));
        end
    end

endmodule
